// File: rtl/bbox_ctrl_pkg.sv
// Shared types and constants for the bounding-box scan controller.
// Holds the FSM state encoding, CSR word addresses and STATUS bit positions.
package bbox_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_CLR,
    ST_RUN,
    ST_CAPTURE,
    ST_DONE,
    ST_ABORT,
    ST_TOUT
  } state_t;

  localparam logic [2:0] CSR_CTRL      = 3'd0;
  localparam logic [2:0] CSR_STATUS    = 3'd1;
  localparam logic [2:0] CSR_BBOX      = 3'd2;
  localparam logic [2:0] CSR_PEEK_ADDR = 3'd3;
  localparam logic [2:0] CSR_PEEK_DATA = 3'd4;
  localparam logic [2:0] CSR_CYCLES    = 3'd5;

  localparam int STAT_BUSY     = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_TOUT     = 2;
  localparam int STAT_PEEK_ERR = 3;

  // The engine owns the memory port in every state from LAUNCH to ABORT.
  function automatic logic is_busy(input state_t s);
    return (s == ST_LAUNCH) || (s == ST_WAIT_CLR) || (s == ST_RUN) ||
           (s == ST_CAPTURE) || (s == ST_ABORT);
  endfunction

endpackage

// File: rtl/bbox_ctrl_if.sv
// Avalon-MM style CSR bus between the HPS lightweight bridge and the controller.
// The host drives the master side; the controller exposes the slave side.
interface bbox_ctrl_if;
  logic [2:0]  csr_addr;
  logic        csr_wr;
  logic        csr_rd;
  logic [31:0] csr_wrdata;
  logic [31:0] csr_rddata;

  modport master (output csr_addr, output csr_wr, output csr_rd, output csr_wrdata,
                  input csr_rddata);
  modport slave  (input csr_addr, input csr_wr, input csr_rd, input csr_wrdata,
                  output csr_rddata);
endinterface

// File: rtl/bbox_csr.sv
// CSR register file: status flags, result latch, peek address and the read mux.
// Decodes CTRL writes into a clear strobe and an accepted-go pulse for the FSM.
module bbox_csr
  import bbox_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  bbox_ctrl_if.slave        bus,
  input  logic              busy,
  input  logic              set_done,
  input  logic              set_tout,
  input  logic [7:0]        xmin,
  input  logic [7:0]        xmax,
  input  logic [7:0]        ymin,
  input  logic [7:0]        ymax,
  input  logic [CNT_W-1:0]  cycles,
  input  logic [DATA_W-1:0] mem_rddata,
  output logic              go,
  output logic              irq,
  output logic [ADDR_W-1:0] peek_addr
);

  logic              done_reg, tout_reg, peek_err_reg, irq_reg;
  logic [31:0]       bbox_reg, rddata_reg, rd_next;
  logic [ADDR_W-1:0] peek_addr_reg;
  logic              ctrl_wr, clear, peek_busy_rd;

  assign ctrl_wr      = bus.csr_wr && (bus.csr_addr == CSR_CTRL);
  assign clear        = ctrl_wr && bus.csr_wrdata[1];
  assign go           = ctrl_wr && bus.csr_wrdata[0] && !busy;
  assign peek_busy_rd = bus.csr_rd && (bus.csr_addr == CSR_PEEK_DATA) && busy;

  assign irq            = irq_reg;
  assign peek_addr      = peek_addr_reg;
  assign bus.csr_rddata = rddata_reg;

  // Mux sees pre-write register values, so a read in the same cycle as a write returns old data.
  always_comb begin
    rd_next = '0;
    case (bus.csr_addr)
      CSR_STATUS: begin
        rd_next[STAT_BUSY]     = busy;
        rd_next[STAT_DONE]     = done_reg;
        rd_next[STAT_TOUT]     = tout_reg;
        rd_next[STAT_PEEK_ERR] = peek_err_reg;
      end
      CSR_BBOX:      rd_next = bbox_reg;
      CSR_PEEK_ADDR: rd_next = 32'(peek_addr_reg);
      CSR_PEEK_DATA: rd_next = busy ? '0 : 32'(mem_rddata);
      CSR_CYCLES:    rd_next = 32'(cycles);
      default:       rd_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_reg      <= 1'b0;
      tout_reg      <= 1'b0;
      peek_err_reg  <= 1'b0;
      irq_reg       <= 1'b0;
      bbox_reg      <= '0;
      rddata_reg    <= '0;
      peek_addr_reg <= '0;
    end else begin
      if (clear || go) begin
        done_reg     <= 1'b0;
        tout_reg     <= 1'b0;
        peek_err_reg <= 1'b0;
      end
      if (clear)
        irq_reg <= 1'b0;
      // Completion events are ordered after clear so a coincident event is never lost.
      if (set_done) begin
        done_reg <= 1'b1;
        irq_reg  <= 1'b1;
        bbox_reg <= {xmax, xmin, ymax, ymin};
      end
      if (set_tout) begin
        tout_reg <= 1'b1;
        irq_reg  <= 1'b1;
      end
      if (peek_busy_rd)
        peek_err_reg <= 1'b1;
      if (bus.csr_wr && (bus.csr_addr == CSR_PEEK_ADDR))
        peek_addr_reg <= ADDR_W'(bus.csr_wrdata);
      if (bus.csr_rd)
        rddata_reg <= rd_next;
    end
  end

endmodule

// File: rtl/bbox_ctrl.sv
// Sequences one boundingBox scan engine, counts scan cycles, aborts on timeout,
// and shares the single image-memory read port between the engine and host peeks.
module bbox_ctrl
  import bbox_ctrl_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 40000,
  parameter int CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  bbox_ctrl_if.slave        csr,
  output logic              irq,
  output logic              eng_rst_n,
  output logic              eng_start,
  input  logic              eng_done,
  input  logic [ADDR_W-1:0] eng_addr,
  output logic [DATA_W-1:0] eng_rddata,
  input  logic [7:0]        eng_xmin,
  input  logic [7:0]        eng_xmax,
  input  logic [7:0]        eng_ymin,
  input  logic [7:0]        eng_ymax,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rddata
);

  // Abort fires on the edge where the count steps onto TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic              busy, go, counting, timeout_hit;
  logic [ADDR_W-1:0] peek_addr;

  assign busy        = is_busy(state_reg);
  assign counting    = (state_reg == ST_LAUNCH) || (state_reg == ST_WAIT_CLR) ||
                       (state_reg == ST_RUN);
  assign timeout_hit = (cnt_reg >= TOUT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE, ST_TOUT: if (go) state_next = ST_LAUNCH;
      ST_LAUNCH:   state_next = ST_WAIT_CLR;
      // A done level left over from the previous scan must fall before results are trusted.
      ST_WAIT_CLR: begin
        if (timeout_hit)    state_next = ST_ABORT;
        else if (!eng_done) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (eng_done)         state_next = ST_CAPTURE;
        else if (timeout_hit) state_next = ST_ABORT;
      end
      ST_CAPTURE:  state_next = ST_DONE;
      ST_ABORT:    state_next = ST_TOUT;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_reg <= '0;
    else if (go)
      cnt_reg <= '0;
    else if (counting && (cnt_reg != '1))
      cnt_reg <= cnt_reg + 1'b1;
  end

  assign eng_start  = (state_reg == ST_LAUNCH);
  assign eng_rst_n  = rst_n && (state_reg != ST_ABORT);
  assign mem_addr   = busy ? eng_addr : peek_addr;
  assign eng_rddata = busy ? mem_rddata : '0;

  bbox_csr #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_csr (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (csr),
    .busy       (busy),
    .set_done   (state_reg == ST_CAPTURE),
    .set_tout   (state_reg == ST_ABORT),
    .xmin       (eng_xmin),
    .xmax       (eng_xmax),
    .ymin       (eng_ymin),
    .ymax       (eng_ymax),
    .cycles     (cnt_reg),
    .mem_rddata (mem_rddata),
    .go         (go),
    .irq        (irq),
    .peek_addr  (peek_addr)
  );

endmodule

// File: tb/tb_bbox_ctrl.sv
// Self-checking bench for bbox_ctrl: behavioural engine and memory models,
// a table of idle CSR vectors, directed scan sequences and randomized scans.
module tb_bbox_ctrl;
  import bbox_ctrl_pkg::*;

  localparam int TOUT = 400;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        irq, eng_rst_n, eng_start;
  logic        eng_done;
  logic [31:0] eng_addr, mem_addr;
  logic [15:0] eng_rddata, mem_rddata;
  logic [7:0]  eng_xmin, eng_xmax, eng_ymin, eng_ymax;

  bbox_ctrl_if bus ();

  bbox_ctrl #(.ADDR_W(32), .DATA_W(16), .TIMEOUT_CYCLES(TOUT), .CNT_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .csr        (bus),
    .irq        (irq),
    .eng_rst_n  (eng_rst_n),
    .eng_start  (eng_start),
    .eng_done   (eng_done),
    .eng_addr   (eng_addr),
    .eng_rddata (eng_rddata),
    .eng_xmin   (eng_xmin),
    .eng_xmax   (eng_xmax),
    .eng_ymin   (eng_ymin),
    .eng_ymax   (eng_ymax),
    .mem_addr   (mem_addr),
    .mem_rddata (mem_rddata)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_model(input logic [31:0] a);
    return a[15:0] ^ 16'h5A3C;
  endfunction

  assign mem_rddata = mem_model(mem_addr);

  // Engine model: done rises cfg_lat edges after the start edge; a prior done level
  // lingers for cfg_hold edges after start; results change only on completion.
  int         cfg_lat = 10, cfg_hold = 0;
  bit         cfg_never = 1'b0;
  logic [7:0] cfg_xmin = 0, cfg_xmax = 0, cfg_ymin = 0, cfg_ymax = 0;
  logic       eng_run;
  int         eng_cnt, eng_hold_cnt;

  assign eng_addr = 32'h0001_0000 + 32'(eng_cnt);

  always @(posedge clk) begin
    if (!eng_rst_n) begin
      eng_run <= 1'b0; eng_done <= 1'b0; eng_cnt <= 0; eng_hold_cnt <= 0;
      eng_xmin <= 8'd0; eng_xmax <= 8'd0; eng_ymin <= 8'd0; eng_ymax <= 8'd0;
    end else if (eng_start) begin
      eng_run <= 1'b1; eng_cnt <= 0; eng_hold_cnt <= cfg_hold;
      if (cfg_hold == 0) eng_done <= 1'b0;
    end else if (eng_run) begin
      if (eng_hold_cnt == 1) eng_done <= 1'b0;
      if (eng_hold_cnt > 0) eng_hold_cnt <= eng_hold_cnt - 1;
      eng_cnt <= eng_cnt + 1;
      if (!cfg_never && (eng_cnt + 1 == cfg_lat)) begin
        eng_done <= 1'b1; eng_run <= 1'b0;
        eng_xmin <= cfg_xmin; eng_xmax <= cfg_xmax;
        eng_ymin <= cfg_ymin; eng_ymax <= cfg_ymax;
      end
    end
  end

  int cyc = 0, starts = 0, start_cyc = 0, rstlows = 0, rstlow_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (eng_start) begin starts <= starts + 1; start_cyc <= cyc; end
    if (rst_n && !eng_rst_n) begin rstlows <= rstlows + 1; rstlow_cyc <= cyc; end
  end

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end else
      $display("ok   %s: 0x%08h", name, got);
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.csr_addr = a; bus.csr_wrdata = d; bus.csr_wr = 1'b1; bus.csr_rd = 1'b0;
    @(negedge clk);
    bus.csr_wr = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.csr_addr = a; bus.csr_rd = 1'b1; bus.csr_wr = 1'b0;
    @(negedge clk);
    bus.csr_rd = 1'b0;
    d = bus.csr_rddata;
  endtask

  task automatic read_check(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    csr_read(a, d);
    check(name, d, exp);
  endtask

  task automatic wait_irq(input int budget, input string name);
    int n = 0;
    while (!irq && n < budget) begin @(negedge clk); n++; end
    check(name, 32'(irq), 32'd1);
  endtask

  // Reference: a completed scan reports done only, the packed results, and
  // LAUNCH + WAIT_CLR + RUN cycles, which always total latency + 2.
  task automatic do_scan(input int lat, input int hold, input logic [7:0] xn, input logic [7:0] xx,
                         input logic [7:0] yn, input logic [7:0] yx, input string tag);
    int s0;
    cfg_lat = lat; cfg_hold = hold; cfg_never = 1'b0;
    cfg_xmin = xn; cfg_xmax = xx; cfg_ymin = yn; cfg_ymax = yx;
    csr_write(CSR_CTRL, 32'h2);
    s0 = starts;
    csr_write(CSR_CTRL, 32'h1);
    if (hold > 0) begin
      repeat (hold + 3) @(negedge clk);
      check({tag, "_no_stale_irq"}, 32'(irq), 32'd0);
    end
    wait_irq(lat + 50, {tag, "_irq"});
    check({tag, "_one_start"}, 32'(starts - s0), 32'd1);
    read_check({tag, "_status"}, CSR_STATUS, 32'h2);
    read_check({tag, "_bbox"}, CSR_BBOX, {xx, xn, yx, yn});
    read_check({tag, "_cycles"}, CSR_CYCLES, 32'(lat + 2));
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [31:0] a;
    int s0, r0;
    bus.csr_addr = 3'd0; bus.csr_wr = 1'b0; bus.csr_rd = 1'b0; bus.csr_wrdata = 32'd0;
    rst_n = 1'b0;

    vecs[0]  = '{1'b0, 1'b1, CSR_STATUS,    32'h0,        1'b1, 32'h0,    "t_status_rst"};
    vecs[1]  = '{1'b0, 1'b1, CSR_BBOX,      32'h0,        1'b1, 32'h0,    "t_bbox_rst"};
    vecs[2]  = '{1'b0, 1'b1, CSR_CYCLES,    32'h0,        1'b1, 32'h0,    "t_cycles_rst"};
    vecs[3]  = '{1'b0, 1'b1, CSR_PEEK_ADDR, 32'h0,        1'b1, 32'h0,    "t_peekaddr_rst"};
    vecs[4]  = '{1'b1, 1'b0, CSR_PEEK_ADDR, 32'h1234,     1'b0, 32'h0,    "t_wr_peekaddr"};
    vecs[5]  = '{1'b0, 1'b1, CSR_PEEK_ADDR, 32'h0,        1'b1, 32'h1234, "t_peekaddr"};
    vecs[6]  = '{1'b0, 1'b1, CSR_PEEK_DATA, 32'h0,        1'b1, 32'h4808, "t_peekdata"};
    vecs[7]  = '{1'b1, 1'b0, 3'd6,          32'hFFFFFFFF, 1'b0, 32'h0,    "t_wr6"};
    vecs[8]  = '{1'b0, 1'b1, 3'd6,          32'h0,        1'b1, 32'h0,    "t_rd6"};
    vecs[9]  = '{1'b0, 1'b1, 3'd7,          32'h0,        1'b1, 32'h0,    "t_rd7"};
    vecs[10] = '{1'b1, 1'b1, CSR_PEEK_ADDR, 32'hBEEF,     1'b1, 32'h1234, "t_rdwr_old"};
    vecs[11] = '{1'b0, 1'b1, CSR_PEEK_ADDR, 32'h0,        1'b1, 32'hBEEF, "t_peekaddr_new"};
    vecs[12] = '{1'b0, 1'b0, CSR_STATUS,    32'h0,        1'b1, 32'hBEEF, "t_rddata_hold"};
    vecs[13] = '{1'b1, 1'b0, CSR_PEEK_ADDR, 32'h1234,     1'b0, 32'h0,    "t_wr_peekaddr2"};

    repeat (3) @(negedge clk);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_eng_start", 32'(eng_start), 32'd0);
    check("rst_eng_rst_n", 32'(eng_rst_n), 32'd0);
    check("rst_rddata", bus.csr_rddata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      bus.csr_addr = vecs[i].addr; bus.csr_wrdata = vecs[i].wdata;
      bus.csr_wr = vecs[i].wr; bus.csr_rd = vecs[i].rd;
      @(negedge clk);
      bus.csr_wr = 1'b0; bus.csr_rd = 1'b0;
      if (vecs[i].chk) check(vecs[i].name, bus.csr_rddata, vecs[i].exp);
    end
    check("idle_mem_addr", mem_addr, 32'h1234);
    check("idle_eng_rddata", 32'(eng_rddata), 32'd0);

    // Timeout: engine never completes.
    cfg_never = 1'b1;
    s0 = starts; r0 = rstlows;
    csr_write(CSR_CTRL, 32'h1);
    wait_irq(TOUT + 100, "to_irq");
    check("to_one_start", 32'(starts - s0), 32'd1);
    check("to_rst_pulses", 32'(rstlows - r0), 32'd1);
    check("to_rst_time", 32'(rstlow_cyc - start_cyc), 32'(TOUT));
    read_check("to_status", CSR_STATUS, 32'h4);
    read_check("to_bbox", CSR_BBOX, 32'h0);
    read_check("to_cycles", CSR_CYCLES, 32'(TOUT));
    cfg_never = 1'b0;

    // go|clear from TOUT, arbitration during the scan, busy peek and busy go.
    cfg_lat = 200; cfg_hold = 0;
    cfg_xmin = 8'd5; cfg_xmax = 8'd60; cfg_ymin = 8'd7; cfg_ymax = 8'd70;
    s0 = starts;
    csr_write(CSR_CTRL, 32'h3);
    check("gc_irq_dropped", 32'(irq), 32'd0);
    read_check("gc_status_busy", CSR_STATUS, 32'h1);
    repeat (10) @(negedge clk);
    check("arb_mem_addr", mem_addr, eng_addr);
    check("arb_eng_rddata", 32'(eng_rddata), 32'(mem_model(eng_addr)));
    read_check("arb_peek_busy", CSR_PEEK_DATA, 32'h0);
    csr_write(CSR_CTRL, 32'h1);
    wait_irq(300, "gc_irq");
    check("gc_one_start", 32'(starts - s0), 32'd1);
    read_check("gc_status", CSR_STATUS, 32'hA);
    read_check("gc_bbox", CSR_BBOX, 32'h3C054607);
    read_check("gc_cycles", CSR_CYCLES, 32'd202);
    csr_write(CSR_CTRL, 32'h2);
    read_check("gc_cleared", CSR_STATUS, 32'h0);

    do_scan(300, 0, 8'd10, 8'd89, 8'd20, 8'd79, "norm");
    // Engine done is still high here; relaunch must wait for it to fall.
    do_scan(50, 5, 8'd0, 8'd99, 8'd0, 8'd99, "relaunch");

    for (int i = 0; i < 5; i++) begin
      int lat;
      a = $urandom;
      csr_write(CSR_PEEK_ADDR, a);
      check($sformatf("rnd%0d_mem_addr", i), mem_addr, a);
      read_check($sformatf("rnd%0d_peek", i), CSR_PEEK_DATA, 32'(mem_model(a)));
      lat = $urandom_range(5, 300);
      do_scan(lat, $urandom_range(0, 3), 8'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom), $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a scan.
    cfg_lat = 300; cfg_hold = 0;
    csr_write(CSR_CTRL, 32'h1);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mr_irq", 32'(irq), 32'd0);
    check("mr_eng_rst_n", 32'(eng_rst_n), 32'd0);
    check("mr_mem_addr", mem_addr, 32'd0);
    check("mr_rddata", bus.csr_rddata, 32'd0);
    rst_n = 1'b1;
    read_check("mr_status", CSR_STATUS, 32'h0);
    check("mr_eng_start", 32'(eng_start), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bbox_ctrl.md
Name: bbox_ctrl

Overview:
- Host-facing controller that sequences one boundingBox scan engine and shares the single image-memory read port between that engine and host pixel peeks.
- Sits between the HPS lightweight Avalon-MM CSR bus and the engine/image ROM on the DE1.
- Launches scans, captures the engine's xMin/xMax/yMin/yMax into stable result registers and counts scan cycles.
- Raises an interrupt on completion and recovers the engine on timeout.

Parameters:
- ADDR_W, 32, image memory address width
- DATA_W, 16, image memory data width
- TIMEOUT_CYCLES, 40000, maximum scan cycles before abort; covers 100x100x3 = 30000 reads plus margin
- CNT_W, 32, width of cycle counter

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- csr_addr  in  3  CSR word address
- csr_wr  in  1  CSR write strobe
- csr_rd  in  1  CSR read strobe
- csr_wrdata  in  32  CSR write data
- csr_rddata  out  32  CSR read data, valid 1 cycle after csr_rd
- irq  out  1  level interrupt, set on done or timeout
- eng_rst_n  out  1  engine synchronous reset (AND of rst_n and internal abort pulse)
- eng_start  out  1  engine start pulse
- eng_done  in  1  engine done level
- eng_addr  in  ADDR_W  engine memory address
- eng_rddata  out  DATA_W  memory data to engine
- eng_xmin, eng_xmax, eng_ymin, eng_ymax  in  8 each  engine results
- mem_addr  out  ADDR_W  image memory address (combinational-read memory)
- mem_rddata  in  DATA_W  image memory data

Behaviour:
- Reset (rst_n=0, synchronous, active-low):
  - state=IDLE; all status bits 0; result register=0; cycle count=0; peek_addr=0.
  - irq=0, eng_start=0, csr_rddata=0.
- CSR map:
  - 0 CTRL (W): bit0 go, bit1 clear.
  - 1 STATUS (R): bit0 busy, bit1 done, bit2 timeout, bit3 peek_err.
  - 2 BBOX (R): {xMax, xMin, yMax, yMin}, MSB first.
  - 3 PEEK_ADDR (R/W).
  - 4 PEEK_DATA (R): mem_rddata at peek_addr.
  - 5 CYCLES (R).
  - 6-7 read 0; writes to them are ignored.
- State machine:
  - IDLE/DONE/TOUT: go -> LAUNCH. go also clears done, timeout and peek_err and zeroes the cycle count.
  - LAUNCH: eng_start=1 for exactly this one cycle -> WAIT_CLR.
  - WAIT_CLR: waits for eng_done=0, which handles a prior finished-state done. eng_done=0 -> RUN.
  - RUN: count +1 per cycle from LAUNCH onward. eng_done=1 -> CAPTURE.
  - CAPTURE: latch the four results into BBOX; done=1; irq=1 -> DONE.
  - Timeout: cycle count reaching TIMEOUT_CYCLES in WAIT_CLR or RUN -> ABORT.
  - ABORT: eng_rst_n=0 for one cycle; timeout=1; irq=1; BBOX unchanged -> TOUT.
- busy = state in {LAUNCH, WAIT_CLR, RUN, CAPTURE, ABORT}.
- go while busy: ignored, no state change.
- clear (bit1): drops irq, done, timeout and peek_err. Does not change state or BBOX.
- go and clear in the same write: clear applies first, then go.
- Arbitration:
  - busy=1: mem_addr=eng_addr and eng_rddata=mem_rddata.
  - Otherwise: mem_addr=peek_addr and eng_rddata=0.
  - The mux is combinational on the registered state, so there is no glitch within a cycle.
- Host peeks:
  - PEEK_DATA read while not busy returns the zero-extended mem_rddata registered on the csr_rd cycle.
  - PEEK_DATA read while busy returns 0 and sets peek_err.
- CSR reads:
  - Registered, 1-cycle latency.
  - csr_rddata holds its last value when csr_rd=0.
  - csr_rd and csr_wr asserted together: the write takes effect and the read returns the pre-write value.
- Cycle counter saturates at all-ones and never wraps.
- rst_n mid-scan: the controller returns to IDLE and eng_rst_n follows rst_n, so both blocks reset together.

Decomposition:
- Package bbox_ctrl_pkg:
  - state enum.
  - CSR address localparams (CTRL=0 … CYCLES=5).
  - STATUS bit indices.
- One natural sub-module: bbox_csr (register file, read mux, clear/go decode).
- The FSM, arbiter mux and counter stay in bbox_ctrl.

Test Plan:
- Normal scan: behavioural engine model asserts eng_done after 30000 cycles with results 10/89/20/79.
  - Write CTRL=1 -> exactly one eng_start pulse.
  - Then busy=1 -> irq=1, STATUS=0x2, BBOX=0x590A4F14, CYCLES ≈ 30002.
- Timeout: engine never raises done.
  - eng_rst_n low for exactly 1 cycle at cycle 40000.
  - STATUS=0x4, irq=1, BBOX unchanged (0).
- Arbitration: write PEEK_ADDR=0x1234 while idle.
  - mem_addr=0x1234 and a PEEK_DATA read returns the mem_rddata value.
  - Start a scan -> mem_addr tracks eng_addr; a PEEK_DATA read during the scan returns 0 and sets STATUS bit3.
- Re-launch from DONE with engine done still high:
  - FSM holds in WAIT_CLR until done falls, and does not capture stale results.
  - Second result set 0/99/0/99 -> BBOX=0x6300_6300.
- go while busy ignored; go|clear (CTRL=3) from TOUT clears the flags and launches a new scan.
- rst_n asserted mid-RUN:
  - Next cycle: state IDLE, irq=0, STATUS=0, eng_rst_n=0.
  - mem_addr=peek_addr=0.
